// File: rtl/data_mem_if.sv
// Request/response bundle between the MIPS datapath and the byte-addressable data memory.
// The master drives the request side, and data_mem_ctrl implements the slave.
interface data_mem_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
    logic              memwrite;
    logic              memread;
    logic [1:0]        size;
    logic              ld_unsigned;
    logic              err_clr;
    logic [31:0]       rd;
    logic              rd_valid;
    logic              ready;
    logic              err;
    logic [ADDR_W-1:0] err_addr;

    // Handshake: once ready is high, every edge that sees memread/memwrite high takes one
    // access. There is no per-transfer backpressure. rd_valid pulses on the edge that samples
    // the load. Requests made while ready is low are dropped and produce no response.
    modport master (
        output addr, wd, memwrite, memread, size, ld_unsigned, err_clr,
        input  rd, rd_valid, ready, err, err_addr
    );

    modport slave (
        input  addr, wd, memwrite, memread, size, ld_unsigned, err_clr,
        output rd, rd_valid, ready, err, err_addr
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressable big-endian data memory with byte/half/word access, registered loads,
// a sticky alignment/range fault register, and a post-reset array clear sequencer.
module data_mem_ctrl #(
    parameter int DEPTH          = 64,
    parameter int ADDR_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    data_mem_if.slave bus,
    output logic      state_dbg
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [31:0]       rd_q, rd_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic [31:0]       mem [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [31:0]       mem_wdata;

    logic              req, in_range, misaligned, fault, do_load, do_store;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic [31:0]       cur_word, merged, load_val;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    assign idx      = bus.addr[IDX_W+1:2];
    assign lane     = bus.addr[1:0];
    assign cur_word = mem[idx];
    assign in_range = (bus.addr >> (IDX_W + 2)) == '0;
    assign req      = ready_q & (bus.memread | bus.memwrite);

    always_comb begin
        misaligned = 1'b0;
        unique case (bus.size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    assign fault    = req & (misaligned | ~in_range);
    assign do_load  = req & ~fault & bus.memread;
    assign do_store = req & ~fault & bus.memwrite;

    // Lane 0 is the most significant byte.
    always_comb begin
        ld_byte = cur_word[7:0];
        unique case (lane)
            2'd0: ld_byte = cur_word[31:24];
            2'd1: ld_byte = cur_word[23:16];
            2'd2: ld_byte = cur_word[15:8];
            2'd3: ld_byte = cur_word[7:0];
        endcase
        ld_half = bus.addr[1] ? cur_word[15:0] : cur_word[31:16];
    end

    always_comb begin
        load_val = cur_word;
        merged   = cur_word;
        unique case (bus.size)
            2'b00: begin
                load_val = bus.ld_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
                unique case (lane)
                    2'd0: merged[31:24] = bus.wd[7:0];
                    2'd1: merged[23:16] = bus.wd[7:0];
                    2'd2: merged[15:8]  = bus.wd[7:0];
                    2'd3: merged[7:0]   = bus.wd[7:0];
                endcase
            end
            2'b01: begin
                load_val = bus.ld_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
                if (bus.addr[1]) merged[15:0] = bus.wd[15:0];
                else             merged[31:16] = bus.wd[15:0];
            end
            default: begin
                load_val = cur_word;
                merged   = bus.wd;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        rd_d       = rd_q;
        rd_valid_d = 1'b0;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        mem_we     = 1'b0;
        mem_idx    = idx;
        mem_wdata  = merged;

        unique case (state_q)
            S_CLEAR: begin
                if (CLEAR_ON_RESET) begin
                    mem_we    = 1'b1;
                    mem_idx   = cnt_q;
                    mem_wdata = '0;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end
            end
            S_RUN: begin
                mem_we = do_store;
                if (do_load) begin
                    rd_d       = load_val;
                    rd_valid_d = 1'b1;
                end
            end
        endcase

        // A new fault outranks a simultaneous clear and re-arms err_addr.
        if (fault) begin
            err_d = 1'b1;
            if (!err_q || bus.err_clr) err_addr_d = bus.addr;
        end else if (bus.err_clr) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_CLEAR;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wdata;
    end

    assign bus.rd       = rd_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.ready    = ready_q;
    assign bus.err      = err_q;
    assign bus.err_addr = err_addr_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed plan steps plus random accesses checked against a
// byte-array model of the memory and fault register.
module tb_data_mem_ctrl;
    logic clk;
    logic rst_n;
    logic state_dbg;
    logic state_dbg2;

    data_mem_if #(.ADDR_W(9)) bif ();
    data_mem_if #(.ADDR_W(4)) bif2 ();

    data_mem_ctrl #(.DEPTH(64), .ADDR_W(9), .CLEAR_ON_RESET(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bif), .state_dbg(state_dbg)
    );

    data_mem_ctrl #(.DEPTH(4), .ADDR_W(4), .CLEAR_ON_RESET(1'b0)) u_noclr (
        .clk(clk), .rst_n(rst_n), .bus(bif2), .state_dbg(state_dbg2)
    );

    int pass_cnt;
    int total_cnt;
    int fail_cnt;

    logic [7:0]  m [0:255];
    logic [31:0] m_rd;
    logic        m_err;
    logic [8:0]  m_err_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        bif.memread     = 1'b0;
        bif.memwrite    = 1'b0;
        bif.err_clr     = 1'b0;
        bif.addr        = '0;
        bif.wd          = '0;
        bif.size        = 2'b10;
        bif.ld_unsigned = 1'b0;
    endtask

    function automatic logic [31:0] model_load(input logic [8:0] a, input logic [1:0] sz,
                                               input logic uns);
        logic [7:0] b;
        b = a[7:0];
        case (sz)
            2'b00:   return uns ? {24'h0, m[b]} : {{24{m[b][7]}}, m[b]};
            2'b01:   return uns ? {16'h0, m[b], m[b+8'd1]}
                                : {{16{m[b][7]}}, m[b], m[b+8'd1]};
            default: return {m[b], m[b+8'd1], m[b+8'd2], m[b+8'd3]};
        endcase
    endfunction

    task automatic model_store(input logic [8:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [7:0] b;
        b = a[7:0];
        case (sz)
            2'b00: m[b] = d[7:0];
            2'b01: begin
                m[b]      = d[15:8];
                m[b+8'd1] = d[7:0];
            end
            default: begin
                m[b]      = d[31:24];
                m[b+8'd1] = d[23:16];
                m[b+8'd2] = d[15:8];
                m[b+8'd3] = d[7:0];
            end
        endcase
    endtask

    // One access cycle: drive on the falling edge, predict, sample 1 time unit after the rising edge.
    task automatic acc(input string tag, input logic r, input logic w, input logic [8:0] a,
                       input logic [1:0] sz, input logic uns, input logic [31:0] d,
                       input logic clr);
        logic flt;
        logic exp_v;
        @(negedge clk);
        bif.addr = a; bif.wd = d; bif.memread = r; bif.memwrite = w;
        bif.size = sz; bif.ld_unsigned = uns; bif.err_clr = clr;
        flt = (r | w) && (sz == 2'b11 || (sz == 2'b01 && a[0]) ||
                          (sz == 2'b10 && a[1:0] != 2'b00) || a >= 9'd256);
        exp_v = 1'b0;
        if (flt) begin
            if (!m_err || clr) m_err_addr = a;
            m_err = 1'b1;
        end else if (clr) begin
            m_err      = 1'b0;
            m_err_addr = '0;
        end
        if (!flt && r) begin
            m_rd  = model_load(a, sz, uns);
            exp_v = 1'b1;
        end
        if (!flt && w) model_store(a, sz, d);
        @(posedge clk);
        #1;
        idle();
        check({tag, ".rd"}, bif.rd, m_rd);
        check({tag, ".rd_valid"}, {31'h0, bif.rd_valid}, {31'h0, exp_v});
        check({tag, ".err"}, {31'h0, bif.err}, {31'h0, m_err});
        check({tag, ".err_addr"}, {23'h0, bif.err_addr}, {23'h0, m_err_addr});
    endtask

    // Entered on a falling edge just after reset release. Random requests must be ignored.
    task automatic clear_cycles(input int ncyc);
        for (int n = 1; n <= ncyc; n++) begin
            bif.memread     = 1'($urandom_range(0, 1));
            bif.memwrite    = 1'($urandom_range(0, 1));
            bif.size        = 2'($urandom_range(0, 3));
            bif.addr        = 9'($urandom_range(0, 511));
            bif.wd          = $urandom;
            bif.ld_unsigned = 1'($urandom_range(0, 1));
            bif.err_clr     = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check($sformatf("clr%0d.ready", n), {31'h0, bif.ready}, {31'h0, (n >= 64)});
            check($sformatf("clr%0d.rd_valid", n), {31'h0, bif.rd_valid}, 32'h0);
            check($sformatf("clr%0d.err", n), {31'h0, bif.err}, 32'h0);
            check($sformatf("clr%0d.rd", n), bif.rd, 32'h0);
            if (n == 1) check("noclr.ready", {31'h0, bif2.ready}, 32'h1);
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        logic       r, w, uns, clr;
        logic [1:0] sz;
        logic [8:0] a;
        logic [8:0] amask;

        pass_cnt = 0; total_cnt = 0; fail_cnt = 0;
        rst_n = 1'b0;
        idle();
        bif2.addr = '0; bif2.wd = '0; bif2.memread = 1'b0; bif2.memwrite = 1'b0;
        bif2.size = 2'b10; bif2.ld_unsigned = 1'b0; bif2.err_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst.rd", bif.rd, 32'h0);
        check("rst.rd_valid", {31'h0, bif.rd_valid}, 32'h0);
        check("rst.ready", {31'h0, bif.ready}, 32'h0);
        check("rst.err", {31'h0, bif.err}, 32'h0);
        check("rst.err_addr", {23'h0, bif.err_addr}, 32'h0);
        check("rst.state", {31'h0, state_dbg}, 32'h0);
        check("rst.noclr_ready", {31'h0, bif2.ready}, 32'h0);

        // First clear is interrupted by an asynchronous reset partway through cycle 30.
        @(negedge clk);
        rst_n = 1'b1;
        clear_cycles(30);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.ready", {31'h0, bif.ready}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_cycles(64);
        check("run.state", {31'h0, state_dbg}, 32'h1);

        for (int i = 0; i < 256; i++) m[i] = 8'h00;
        m_rd = 32'h0; m_err = 1'b0; m_err_addr = '0;

        acc("ld_fc", 1'b1, 1'b0, 9'h0FC, 2'b10, 1'b0, 32'h0, 1'b0);
        check("ld_fc.const", bif.rd, 32'h0000_0000);

        acc("st_w10", 1'b0, 1'b1, 9'h010, 2'b10, 1'b0, 32'h1122_3344, 1'b0);
        acc("st_b12", 1'b0, 1'b1, 9'h012, 2'b00, 1'b0, 32'h0000_00AB, 1'b0);
        acc("ld_w10", 1'b1, 1'b0, 9'h010, 2'b10, 1'b0, 32'h0, 1'b0);
        check("ld_w10.const", bif.rd, 32'h1122_AB44);
        acc("ld_bs12", 1'b1, 1'b0, 9'h012, 2'b00, 1'b0, 32'h0, 1'b0);
        check("ld_bs12.const", bif.rd, 32'hFFFF_FFAB);
        acc("ld_bu12", 1'b1, 1'b0, 9'h012, 2'b00, 1'b1, 32'h0, 1'b0);
        check("ld_bu12.const", bif.rd, 32'h0000_00AB);

        acc("st_h22", 1'b0, 1'b1, 9'h022, 2'b01, 1'b0, 32'h0000_8001, 1'b0);
        acc("ld_w20", 1'b1, 1'b0, 9'h020, 2'b10, 1'b0, 32'h0, 1'b0);
        check("ld_w20.const", bif.rd, 32'h0000_8001);
        acc("ld_hs22", 1'b1, 1'b0, 9'h022, 2'b01, 1'b0, 32'h0, 1'b0);
        check("ld_hs22.const", bif.rd, 32'hFFFF_8001);
        acc("ld_hu22", 1'b1, 1'b0, 9'h022, 2'b01, 1'b1, 32'h0, 1'b0);
        check("ld_hu22.const", bif.rd, 32'h0000_8001);

        acc("flt_w06", 1'b1, 1'b0, 9'h006, 2'b10, 1'b0, 32'h0, 1'b0);
        check("flt_w06.rd_hold", bif.rd, 32'h0000_8001);
        check("flt_w06.err_addr", {23'h0, bif.err_addr}, 32'h006);
        acc("flt_h03", 1'b0, 1'b1, 9'h003, 2'b01, 1'b0, 32'h0000_FFFF, 1'b0);
        check("flt_h03.err_addr", {23'h0, bif.err_addr}, 32'h006);
        acc("ld_w00", 1'b1, 1'b0, 9'h000, 2'b10, 1'b0, 32'h0, 1'b0);
        check("ld_w00.const", bif.rd, 32'h0);
        acc("errclr1", 1'b0, 1'b0, 9'h000, 2'b10, 1'b0, 32'h0, 1'b1);
        check("errclr1.err", {31'h0, bif.err}, 32'h0);

        acc("flt_100", 1'b1, 1'b0, 9'h100, 2'b10, 1'b0, 32'h0, 1'b0);
        check("flt_100.err_addr", {23'h0, bif.err_addr}, 32'h100);
        acc("errclr2", 1'b0, 1'b0, 9'h000, 2'b10, 1'b0, 32'h0, 1'b1);

        acc("st_w30", 1'b0, 1'b1, 9'h030, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
        acc("rw_w30", 1'b1, 1'b1, 9'h030, 2'b10, 1'b0, 32'h0, 1'b0);
        check("rw_w30.const", bif.rd, 32'hDEAD_BEEF);
        acc("ld_w30", 1'b1, 1'b0, 9'h030, 2'b10, 1'b0, 32'h0, 1'b0);
        check("ld_w30.const", bif.rd, 32'h0);

        acc("flt_05", 1'b1, 1'b0, 9'h005, 2'b10, 1'b0, 32'h0, 1'b0);
        acc("flt_clr07", 1'b1, 1'b0, 9'h007, 2'b11, 1'b0, 32'h0, 1'b1);
        check("flt_clr07.err", {31'h0, bif.err}, 32'h1);
        check("flt_clr07.err_addr", {23'h0, bif.err_addr}, 32'h007);
        acc("errclr3", 1'b0, 1'b0, 9'h000, 2'b10, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            r   = 1'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 15) == 0);
            sz  = ($urandom_range(0, 9) < 9) ? 2'($urandom_range(0, 2)) : 2'b11;
            if ($urandom_range(0, 9) < 9) a = 9'($urandom_range(0, 63));
            else                          a = 9'($urandom_range(256, 511));
            amask = (sz == 2'b10) ? 9'h1FC : (sz == 2'b01) ? 9'h1FE : 9'h1FF;
            if ($urandom_range(0, 3) != 0) a = a & amask;
            acc($sformatf("rnd%0d", i), r, w, a, sz, uns, $urandom, clr);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
